// File: rtl/uart_rx_fifo_ctrl.sv
// UART receive front-end: oversampled deserialiser with parity/framing tags, a one-entry
// hold register and a single-clock FIFO feeding the register/DMA reader.
module uart_rx_fifo_ctrl #(
  parameter int DATA_BITS  = 8,
  parameter int OVS        = 16,
  parameter int FIFO_DEPTH = 16,
  parameter int AW         = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   en,
  input  logic                   baud_tick,
  input  logic                   rxd,
  input  logic                   cfg_par_en,
  input  logic                   cfg_par_odd,
  input  logic                   cfg_stop2,
  input  logic                   rd_en,
  output logic [DATA_BITS+1:0]   rd_data,
  output logic                   empty,
  output logic                   full,
  output logic [AW:0]            usedw,
  output logic                   overflow,
  output logic [7:0]             ovf_cnt,
  input  logic                   ovf_clr
);

  localparam int W  = DATA_BITS + 2;
  localparam int CW = $clog2(OVS);
  localparam int BW = $clog2(DATA_BITS);

  localparam logic [CW-1:0] HALF_M1  = CW'(OVS / 2 - 1);
  localparam logic [CW-1:0] FULL_M1  = CW'(OVS - 1);
  localparam logic [BW-1:0] LAST_BIT = BW'(DATA_BITS - 1);
  localparam logic [AW:0]   DEPTH_V  = (AW + 1)'(FIFO_DEPTH);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_START  = 3'd1;
  localparam logic [2:0] S_DATA   = 3'd2;
  localparam logic [2:0] S_PARITY = 3'd3;
  localparam logic [2:0] S_STOP1  = 3'd4;
  localparam logic [2:0] S_STOP2  = 3'd5;

  logic                 rxd_s1_q, rxd_s2_q;
  logic [2:0]           state_q, state_d;
  logic [CW-1:0]        tick_cnt_q, tick_cnt_d;
  logic [BW-1:0]        bit_cnt_q, bit_cnt_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic                 par_en_q, par_en_d;
  logic                 par_odd_q, par_odd_d;
  logic                 stop2_q, stop2_d;
  logic                 par_err_q, par_err_d;
  logic                 frame_err_q, frame_err_d;

  logic [W-1:0]         hold_q, hold_d;
  logic                 hold_vld_q, hold_vld_d;
  logic [AW-1:0]        wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]        rd_ptr_q, rd_ptr_d;
  logic [AW:0]          usedw_q, usedw_d;
  logic [W-1:0]         rd_data_q, rd_data_d;
  logic                 overflow_q, overflow_d;
  logic [7:0]           ovf_cnt_q, ovf_cnt_d;

  logic [W-1:0]         mem_q [FIFO_DEPTH];

  logic                 rxd_sync;
  logic                 mid_bit;
  logic                 stop_fe;
  logic                 comp;
  logic [W-1:0]         comp_word;
  logic                 can_wr;
  logic                 pop;
  logic                 push;
  logic [W-1:0]         push_word;
  logic                 drop;

  assign rxd_sync = rxd_s2_q;
  assign mid_bit  = (tick_cnt_q == FULL_M1);

  // Receive FSM: every transition is gated by baud_tick; cfg is captured once per character.
  always_comb begin
    state_d     = state_q;
    tick_cnt_d  = tick_cnt_q;
    bit_cnt_d   = bit_cnt_q;
    shift_d     = shift_q;
    par_en_d    = par_en_q;
    par_odd_d   = par_odd_q;
    stop2_d     = stop2_q;
    par_err_d   = par_err_q;
    frame_err_d = frame_err_q;
    stop_fe     = frame_err_q | ~rxd_sync;
    comp        = 1'b0;
    comp_word   = {stop_fe, par_err_q, shift_q};

    if (!en) begin
      state_d    = S_IDLE;
      tick_cnt_d = '0;
    end else if (baud_tick) begin
      case (state_q)
        S_IDLE: begin
          if (!rxd_sync) begin
            state_d     = S_START;
            tick_cnt_d  = '0;
            bit_cnt_d   = '0;
            par_en_d    = cfg_par_en;
            par_odd_d   = cfg_par_odd;
            stop2_d     = cfg_stop2;
            par_err_d   = 1'b0;
            frame_err_d = 1'b0;
          end
        end
        S_START: begin
          if (tick_cnt_q == HALF_M1) begin
            tick_cnt_d = '0;
            state_d    = rxd_sync ? S_IDLE : S_DATA;
          end else begin
            tick_cnt_d = tick_cnt_q + 1'b1;
          end
        end
        default: begin
          if (!mid_bit) begin
            tick_cnt_d = tick_cnt_q + 1'b1;
          end else begin
            tick_cnt_d = '0;
            case (state_q)
              S_DATA: begin
                shift_d = {rxd_sync, shift_q[DATA_BITS-1:1]};
                if (bit_cnt_q == LAST_BIT) begin
                  state_d = par_en_q ? S_PARITY : S_STOP1;
                end else begin
                  bit_cnt_d = bit_cnt_q + 1'b1;
                end
              end
              S_PARITY: begin
                par_err_d = ((^shift_q) ^ rxd_sync) != par_odd_q;
                state_d   = S_STOP1;
              end
              S_STOP1: begin
                if (stop2_q) begin
                  frame_err_d = stop_fe;
                  state_d     = S_STOP2;
                end else begin
                  comp    = 1'b1;
                  state_d = S_IDLE;
                end
              end
              S_STOP2: begin
                comp    = 1'b1;
                state_d = S_IDLE;
              end
              default: state_d = S_IDLE;
            endcase
          end
        end
      endcase
    end
  end

  // Buffering: completion owns the write port on its edge; otherwise a valid hold drains.
  always_comb begin
    can_wr     = (usedw_q != DEPTH_V);
    pop        = rd_en && (usedw_q != '0);
    push       = 1'b0;
    push_word  = hold_q;
    drop       = 1'b0;
    hold_d     = hold_q;
    hold_vld_d = hold_vld_q;

    if (comp) begin
      if (!hold_vld_q) begin
        if (can_wr) begin
          push      = 1'b1;
          push_word = comp_word;
        end else begin
          hold_d     = comp_word;
          hold_vld_d = 1'b1;
        end
      end else begin
        drop = 1'b1;
      end
    end else if (hold_vld_q && can_wr) begin
      push       = 1'b1;
      push_word  = hold_q;
      hold_vld_d = 1'b0;
    end

    wr_ptr_d  = push ? wr_ptr_q + 1'b1 : wr_ptr_q;
    rd_ptr_d  = pop ? rd_ptr_q + 1'b1 : rd_ptr_q;
    rd_data_d = pop ? mem_q[rd_ptr_q] : rd_data_q;

    case ({push, pop})
      2'b10:   usedw_d = usedw_q + 1'b1;
      2'b01:   usedw_d = usedw_q - 1'b1;
      default: usedw_d = usedw_q;
    endcase

    overflow_d = overflow_q;
    ovf_cnt_d  = ovf_cnt_q;
    if (drop) begin
      overflow_d = 1'b1;
      if (ovf_clr) begin
        ovf_cnt_d = 8'd1;
      end else if (ovf_cnt_q != 8'hFF) begin
        ovf_cnt_d = ovf_cnt_q + 8'd1;
      end
    end else if (ovf_clr) begin
      overflow_d = 1'b0;
      ovf_cnt_d  = 8'd0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rxd_s1_q    <= 1'b1;
      rxd_s2_q    <= 1'b1;
      state_q     <= S_IDLE;
      tick_cnt_q  <= '0;
      bit_cnt_q   <= '0;
      shift_q     <= '0;
      par_en_q    <= 1'b0;
      par_odd_q   <= 1'b0;
      stop2_q     <= 1'b0;
      par_err_q   <= 1'b0;
      frame_err_q <= 1'b0;
      hold_q      <= '0;
      hold_vld_q  <= 1'b0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      usedw_q     <= '0;
      rd_data_q   <= '0;
      overflow_q  <= 1'b0;
      ovf_cnt_q   <= 8'd0;
    end else begin
      rxd_s1_q    <= rxd;
      rxd_s2_q    <= rxd_s1_q;
      state_q     <= state_d;
      tick_cnt_q  <= tick_cnt_d;
      bit_cnt_q   <= bit_cnt_d;
      shift_q     <= shift_d;
      par_en_q    <= par_en_d;
      par_odd_q   <= par_odd_d;
      stop2_q     <= stop2_d;
      par_err_q   <= par_err_d;
      frame_err_q <= frame_err_d;
      hold_q      <= hold_d;
      hold_vld_q  <= hold_vld_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      usedw_q     <= usedw_d;
      rd_data_q   <= rd_data_d;
      overflow_q  <= overflow_d;
      ovf_cnt_q   <= ovf_cnt_d;
    end
  end

  // Storage array carries no reset so it can map onto block RAM.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wr_ptr_q] <= push_word;
    end
  end

  assign rd_data  = rd_data_q;
  assign empty    = (usedw_q == '0);
  assign full     = (usedw_q == DEPTH_V);
  assign usedw    = usedw_q;
  assign overflow = overflow_q;
  assign ovf_cnt  = ovf_cnt_q;

endmodule

// File: tb/tb_uart_rx_fifo_ctrl.sv
// Scoreboard bench for uart_rx_fifo_ctrl: serial frames are driven on rxd, expected
// tagged words are queued at send time and compared as the FIFO is popped.
module tb_uart_rx_fifo_ctrl;

  localparam int OVS      = 16;
  localparam int TICK_DIV = 2;
  localparam int BIT      = OVS * TICK_DIV;

  logic       clk = 1'b0;
  logic       rst;
  logic       en;
  logic       baud_tick;
  logic       rxd;
  logic       cfg_par_en;
  logic       cfg_par_odd;
  logic       cfg_stop2;
  logic       rd_en;
  logic [9:0] rd_data;
  logic       empty;
  logic       full;
  logic [4:0] usedw;
  logic       overflow;
  logic [7:0] ovf_cnt;
  logic       ovf_clr;

  int checks = 0;
  int errors = 0;
  logic [9:0] exp_q[$];
  logic       tick_ph = 1'b0;

  uart_rx_fifo_ctrl #(.DATA_BITS(8), .OVS(OVS), .FIFO_DEPTH(16), .AW(4)) dut (
    .clk(clk), .rst(rst), .en(en), .baud_tick(baud_tick), .rxd(rxd),
    .cfg_par_en(cfg_par_en), .cfg_par_odd(cfg_par_odd), .cfg_stop2(cfg_stop2),
    .rd_en(rd_en), .rd_data(rd_data), .empty(empty), .full(full), .usedw(usedw),
    .overflow(overflow), .ovf_cnt(ovf_cnt), .ovf_clr(ovf_clr)
  );

  always #5 clk = ~clk;

  initial begin
    baud_tick = 1'b0;
    forever begin
      @(negedge clk);
      tick_ph   = ~tick_ph;
      baud_tick = tick_ph;
    end
  end

  initial begin
    #(900_000);
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  task automatic drive_bit(input logic b, input int clks);
    rxd = b;
    repeat (clks) @(negedge clk);
  endtask

  task automatic send_char(input logic [7:0] d, input logic par_en, input logic par_bit,
                           input logic two_stop, input logic stop2_val);
    drive_bit(1'b0, BIT);
    for (int i = 0; i < 8; i++) drive_bit(d[i], BIT);
    if (par_en) drive_bit(par_bit, BIT);
    drive_bit(1'b1, BIT);
    if (two_stop) begin
      if (stop2_val) drive_bit(1'b1, BIT);
      else begin
        drive_bit(1'b0, BIT * 3 / 4);
        drive_bit(1'b1, BIT / 4);
      end
    end
    $display("sent 0x%02h", d);
  endtask

  task automatic pop_word(output logic [9:0] w, output bit ok);
    int n = 0;
    while (empty && n < 4 * BIT) begin
      @(negedge clk);
      n++;
    end
    ok = !empty;
    w  = 'x;
    if (ok) begin
      rd_en = 1'b1;
      @(negedge clk);
      rd_en = 1'b0;
      w = rd_data;
      $display("pop 0x%03h", w);
    end
  endtask

  task automatic test_reset();
    rst = 1'b0; en = 1'b1; rxd = 1'b1; rd_en = 1'b0; ovf_clr = 1'b0;
    cfg_par_en = 1'b0; cfg_par_odd = 1'b0; cfg_stop2 = 1'b0;
    repeat (4) @(negedge clk);
    checks++; if (empty !== 1'b1) begin errors++; $display("FAIL reset_empty: got %b expected 1", empty); end
    checks++; if (full !== 1'b0) begin errors++; $display("FAIL reset_full: got %b expected 0", full); end
    checks++; if (usedw !== 5'd0) begin errors++; $display("FAIL reset_usedw: got %0d expected 0", usedw); end
    checks++; if (rd_data !== 10'h0) begin errors++; $display("FAIL reset_rd_data: got %h expected 000", rd_data); end
    checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL reset_overflow: got %b expected 0", overflow); end
    checks++; if (ovf_cnt !== 8'd0) begin errors++; $display("FAIL reset_ovf_cnt: got %0d expected 0", ovf_cnt); end
    rst = 1'b1;
    repeat (8) @(negedge clk);
  endtask

  task automatic test_8n1();
    logic [9:0] got, exp; bit ok;
    send_char(8'hA5, 1'b0, 1'b0, 1'b0, 1'b1);
    exp_q.push_back(10'h0A5);
    checks++; if (usedw !== 5'd1) begin errors++; $display("FAIL 8n1_usedw: got %0d expected 1", usedw); end
    checks++; if (empty !== 1'b0) begin errors++; $display("FAIL 8n1_empty: got %b expected 0", empty); end
    pop_word(got, ok);
    exp = exp_q.pop_front();
    checks++; if (!ok || got !== exp) begin errors++; $display("FAIL 8n1_data: got %h expected %h", got, exp); end
    checks++; if (empty !== 1'b1) begin errors++; $display("FAIL 8n1_empty_after_pop: got %b expected 1", empty); end
  endtask

  task automatic test_parity();
    logic [9:0] got, exp; bit ok;
    cfg_par_en = 1'b1; cfg_par_odd = 1'b0;
    send_char(8'h07, 1'b1, 1'b0, 1'b0, 1'b1); exp_q.push_back(10'h107);
    send_char(8'h07, 1'b1, 1'b1, 1'b0, 1'b1); exp_q.push_back(10'h007);
    cfg_par_odd = 1'b1;
    send_char(8'h07, 1'b1, 1'b0, 1'b0, 1'b1); exp_q.push_back(10'h007);
    cfg_par_en = 1'b0; cfg_par_odd = 1'b0;
    for (int i = 0; i < 3; i++) begin
      pop_word(got, ok);
      exp = exp_q.pop_front();
      checks++; if (!ok || got !== exp) begin errors++; $display("FAIL parity_%0d: got %h expected %h", i, got, exp); end
    end
  endtask

  task automatic test_frame();
    logic [9:0] got, exp; bit ok;
    cfg_stop2 = 1'b1;
    send_char(8'h3C, 1'b0, 1'b0, 1'b1, 1'b0); exp_q.push_back(10'h23C);
    drive_bit(1'b1, 2 * BIT);
    send_char(8'h3C, 1'b0, 1'b0, 1'b1, 1'b1); exp_q.push_back(10'h03C);
    cfg_stop2 = 1'b0;
    for (int i = 0; i < 2; i++) begin
      pop_word(got, ok);
      exp = exp_q.pop_front();
      checks++; if (!ok || got !== exp) begin errors++; $display("FAIL frame_%0d: got %h expected %h", i, got, exp); end
    end
  endtask

  task automatic test_false_start();
    logic [9:0] got, exp; bit ok;
    drive_bit(1'b0, 4 * TICK_DIV);
    drive_bit(1'b1, 2 * BIT);
    checks++; if (usedw !== 5'd0) begin errors++; $display("FAIL false_start_usedw: got %0d expected 0", usedw); end
    checks++; if (empty !== 1'b1) begin errors++; $display("FAIL false_start_empty: got %b expected 1", empty); end
    send_char(8'h5A, 1'b0, 1'b0, 1'b0, 1'b1); exp_q.push_back(10'h05A);
    pop_word(got, ok);
    exp = exp_q.pop_front();
    checks++; if (!ok || got !== exp) begin errors++; $display("FAIL false_start_next: got %h expected %h", got, exp); end
  endtask

  task automatic test_enable();
    en = 1'b0;
    send_char(8'h99, 1'b0, 1'b0, 1'b0, 1'b1);
    drive_bit(1'b1, BIT);
    checks++; if (usedw !== 5'd0) begin errors++; $display("FAIL enable_low_usedw: got %0d expected 0", usedw); end
    en = 1'b1;
    drive_bit(1'b1, BIT);
  endtask

  task automatic test_back_to_back_overflow();
    logic [9:0] got, exp; bit ok;
    for (int i = 0; i < 18; i++) begin
      logic [7:0] d;
      d = 8'(i * 29 + 5);
      send_char(d, 1'b0, 1'b0, 1'b0, 1'b1);
      if (i < 17) exp_q.push_back({2'b00, d});
    end
    checks++; if (usedw !== 5'd16) begin errors++; $display("FAIL ovf_usedw: got %0d expected 16", usedw); end
    checks++; if (full !== 1'b1) begin errors++; $display("FAIL ovf_full: got %b expected 1", full); end
    checks++; if (overflow !== 1'b1) begin errors++; $display("FAIL ovf_flag: got %b expected 1", overflow); end
    checks++; if (ovf_cnt !== 8'd1) begin errors++; $display("FAIL ovf_cnt: got %0d expected 1", ovf_cnt); end
    pop_word(got, ok);
    exp = exp_q.pop_front();
    checks++; if (!ok || got !== exp) begin errors++; $display("FAIL ovf_first_pop: got %h expected %h", got, exp); end
    checks++; if (usedw !== 5'd15) begin errors++; $display("FAIL ovf_usedw_after_pop: got %0d expected 15", usedw); end
    @(negedge clk);
    checks++; if (usedw !== 5'd16) begin errors++; $display("FAIL ovf_hold_drain: got %0d expected 16", usedw); end
    ovf_clr = 1'b1;
    @(negedge clk);
    ovf_clr = 1'b0;
    checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL ovf_clr_flag: got %b expected 0", overflow); end
    checks++; if (ovf_cnt !== 8'd0) begin errors++; $display("FAIL ovf_clr_cnt: got %0d expected 0", ovf_cnt); end
    for (int i = 0; i < 16; i++) begin
      pop_word(got, ok);
      exp = exp_q.pop_front();
      checks++; if (!ok || got !== exp) begin errors++; $display("FAIL ovf_drain_%0d: got %h expected %h", i, got, exp); end
    end
    checks++; if (empty !== 1'b1) begin errors++; $display("FAIL ovf_final_empty: got %b expected 1", empty); end
  endtask

  task automatic test_reset_mid_char();
    logic [9:0] got, exp; bit ok;
    send_char(8'h11, 1'b0, 1'b0, 1'b0, 1'b1);
    send_char(8'h22, 1'b0, 1'b0, 1'b0, 1'b1);
    send_char(8'h33, 1'b0, 1'b0, 1'b0, 1'b1);
    checks++; if (usedw !== 5'd3) begin errors++; $display("FAIL rstmid_queued: got %0d expected 3", usedw); end
    drive_bit(1'b0, BIT);
    drive_bit(1'b1, BIT);
    drive_bit(1'b0, BIT / 2);
    rst = 1'b0;
    #1;
    checks++; if (empty !== 1'b1) begin errors++; $display("FAIL rstmid_empty: got %b expected 1", empty); end
    checks++; if (usedw !== 5'd0) begin errors++; $display("FAIL rstmid_usedw: got %0d expected 0", usedw); end
    checks++; if (rd_data !== 10'h0) begin errors++; $display("FAIL rstmid_rd_data: got %h expected 000", rd_data); end
    rxd = 1'b1;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    drive_bit(1'b1, 2 * BIT);
    checks++; if (usedw !== 5'd0) begin errors++; $display("FAIL rstmid_partial_lost: got %0d expected 0", usedw); end
    send_char(8'hC3, 1'b0, 1'b0, 1'b0, 1'b1); exp_q.push_back(10'h0C3);
    pop_word(got, ok);
    exp = exp_q.pop_front();
    checks++; if (!ok || got !== exp) begin errors++; $display("FAIL rstmid_next_char: got %h expected %h", got, exp); end
  endtask

  initial begin
    test_reset();
    test_8n1();
    test_parity();
    test_frame();
    test_false_start();
    test_enable();
    test_back_to_back_overflow();
    test_reset_mid_char();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
